led_capture: RTL and testbench
==============================

Name: led_capture

Overview:
- Receive-side counterpart of the POV display path: recovers the serial pixel stream driven on the LED line back into bytes.
- Measures the revolution period from the sensor pulse and derives the per-pixel bit period from it (32 pixels/revolution).
- Samples the LED line mid-pixel, assembles 8-bit bytes MSB-first and writes 4 bytes per revolution into a 16-byte capture RAM.
- Used as a loopback checker and pattern recorder alongside the display.

Parameters:
CNT_W, 32, width of period counter and period register
PIX_SHIFT, 5, log2 of pixels per revolution (32 pixels -> 4 bytes)
ADDR_W, 4, capture RAM address width (16 bytes = 4 revolution slots)

Ports:
clk  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
sensor  in  1  asynchronous revolution marker; rising edge = start of revolution
led  in  1  serial pixel stream, synchronous to clk
wr_en  out  1  one-cycle write strobe to capture RAM
wr_addr  out  ADDR_W  capture RAM byte address
wr_data  out  8  assembled byte, MSB = first pixel
frame_done  out  1  one-cycle pulse when 32 pixels of a revolution are captured
short_rev  out  1  one-cycle pulse when a sensor edge aborts an incomplete frame
too_fast  out  1  level; high while the latched bit period is < 2
period  out  CNT_W  last measured revolution period in clk cycles

Behaviour:
- Reset (reset=1 at clk edge): all outputs 0; state IDLE; counters, slot, bit and byte indices 0. Reset mid-frame discards any partial byte; no write is issued.
- sensor passes through a 2-FF synchronizer plus rising-edge detect, giving a 1-cycle edge pulse 3 cycles after the raw rise.
- Period counter increments every cycle and saturates at 2^CNT_W-1. On edge: period <= counter, counter <= 0.
- bit_period = period >> PIX_SHIFT. sample_pt = bit_period >> 1.
- too_fast = (bit_period < 2), re-evaluated on each period update.
- States:
  - IDLE: on edge -> CALIB. No writes.
  - CALIB: on edge, latch period. If too_fast, stay CALIB; else -> CAPTURE with bit timer = 0 and bit_idx = 0.
  - CAPTURE: bit timer counts 0..bit_period-1.
    - At timer == sample_pt, shift led into the byte register.
    - At timer == bit_period-1, bit_idx++ and timer resets.
    - When bit_idx[2:0] wraps 7->0, the next cycle gives wr_en=1, wr_data=byte, wr_addr={slot, byte_idx}, then byte_idx++.
    - After bit 31 completes: frame_done pulse (same cycle as the 4th write), slot++ (mod 4) -> WAIT.
  - WAIT: ignore led. On edge, latch period. If too_fast -> CALIB; else -> CAPTURE.
- Edge in CAPTURE before bit 31 completes:
  - short_rev pulse; partial byte dropped; bytes already written stay.
  - slot++; period updated; restart at bit 0 (or -> CALIB if too_fast).
- Edge on the same cycle bit 31 completes: the frame counts as complete. frame_done fires, no short_rev, and the next frame starts immediately.
- wr_addr wraps 15 -> 0 (slot 3 -> 0).
- Latency from the edge pulse to the first sample: sample_pt+1 cycles.

Decomposition:
- Shared package pov_pkg:
  - state enum {IDLE, CALIB, CAPTURE, WAIT}
  - PIX_PER_REV=32, BITS_PER_BYTE=8, BYTES_PER_REV=4
- One sub-module: edge_sync (2-FF synchronizer + rising-edge pulse), reusable by the display-side sensor logic.

Test Plan:
- Reset, sensor edges every 320 cycles, led driven MSB-first as 0xA5,0x3C,0xFF,0x00 with 10-cycle pixels -> after the 2nd edge, writes addr 0..3 with A5,3C,FF,00; period=320; frame_done once.
- Continue 5 revolutions, incrementing the first byte each revolution -> addrs 4..7, 8..11, 12..15, then 0..3 again (wrap); data matches.
- Capture at period 320, then an edge after 160 cycles -> short_rev pulse, only 2 bytes written in that slot, period=160, next frame uses bit_period 5.
- Edge periods of 60 cycles (bit_period 1) -> too_fast=1, state stays CALIB, no wr_en. Then period 640 -> too_fast=0, capture resumes with bit_period 20.
- reset asserted at bit 13 of a frame -> no further wr_en, all outputs 0 next cycle; capture resumes only after two new edges.
- Edge placed exactly on the completion cycle of bit 31 -> 4 writes, frame_done=1, short_rev=0, next slot capture starts.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared definitions for the POV display / capture pair.
// Provides the capture FSM state encoding and the fixed frame geometry
// (pixels per revolution, bits per byte, bytes per revolution).
package pov_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALIB   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  localparam int PIX_PER_REV   = 32;
  localparam int BITS_PER_BYTE = 8;
  localparam int BYTES_PER_REV = PIX_PER_REV / BITS_PER_BYTE;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   din   - asynchronous input
//   pulse - one-cycle pulse, three cycles after din rises
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/led_capture.sv
// Recovers the serial POV pixel stream on the LED line back into bytes.
// The revolution period is measured between sensor edges; each of the 32
// pixels lasts period/32 cycles and is sampled at its midpoint. Bytes are
// assembled MSB-first and written four per revolution into a 16-byte RAM
// organised as four revolution slots.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   sensor      - asynchronous revolution marker (rising edge)
//   led         - serial pixel stream, synchronous to clk
//   wr_en       - one-cycle capture RAM write strobe
//   wr_addr     - capture RAM byte address {slot, byte index}
//   wr_data     - assembled byte, MSB is the first pixel
//   frame_done  - pulse when all 32 pixels of a revolution are captured
//   short_rev   - pulse when a sensor edge cuts a frame short
//   too_fast    - level, latched bit period below 2 cycles
//   period      - last measured revolution period in clk cycles
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | after reset, waiting for the first edge to start counting
// ST_CALIB   | period not yet usable (unknown or too fast), no capture
// ST_CAPTURE | sampling pixels of the current revolution
// ST_WAIT    | frame complete, led ignored until the next edge
module led_capture
  import pov_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int PIX_SHIFT = 5,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor,
  input  logic              led,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              short_rev,
  output logic              too_fast,
  output logic [CNT_W-1:0]  period
);

  localparam int BYTE_IDX_W = PIX_SHIFT - 3;
  localparam int SLOT_W     = ADDR_W - BYTE_IDX_W;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic                 too_fast_q, too_fast_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [PIX_SHIFT-1:0] bit_idx_q, bit_idx_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [7:0]           byte_q, byte_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 short_rev_q, short_rev_d;

  logic                 edge_pulse;
  logic [CNT_W-1:0]     bit_period;
  logic [CNT_W-1:0]     sample_pt;
  logic [CNT_W-1:0]     period_new;
  logic                 tf_new;
  logic                 bit_end;
  logic                 last_bit;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sensor),
    .pulse (edge_pulse)
  );

  assign bit_period = period_q >> PIX_SHIFT;
  assign sample_pt  = bit_period >> 1;

  // The counter restarts at 0 on the edge cycle, so the cycle count between
  // two edges is the counter value plus one (saturating).
  assign period_new = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign tf_new     = (period_new >> PIX_SHIFT) < CNT_W'(2);

  assign bit_end  = (timer_q == bit_period - CNT_W'(1));
  assign last_bit = bit_end && (bit_idx_q == '1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    period_d     = period_q;
    too_fast_d   = too_fast_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    slot_d       = slot_q;
    byte_d       = byte_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    short_rev_d  = 1'b0;

    if (edge_pulse) begin
      cnt_d      = '0;
      period_d   = period_new;
      too_fast_d = tf_new;
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_pulse) state_d = ST_CALIB;
      end

      ST_CALIB, ST_WAIT: begin
        if (edge_pulse) begin
          state_d   = tf_new ? ST_CALIB : ST_CAPTURE;
          timer_d   = '0;
          bit_idx_d = '0;
          byte_d    = '0;
        end
      end

      ST_CAPTURE: begin
        timer_d = timer_q + CNT_W'(1);
        if (timer_q == sample_pt) byte_d = {byte_q[6:0], led};
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = bit_idx_q + PIX_SHIFT'(1);
          // byte_d already holds the last sample when sample and bit end coincide
          if (bit_idx_q[2:0] == 3'd7) begin
            wr_en_d   = 1'b1;
            wr_data_d = byte_d;
            wr_addr_d = {slot_q, bit_idx_q[PIX_SHIFT-1:3]};
          end
          if (last_bit) begin
            frame_done_d = 1'b1;
            slot_d       = slot_q + SLOT_W'(1);
            state_d      = ST_WAIT;
          end
        end
        // An edge landing on the final bit still counts as a full frame;
        // any earlier edge abandons the rest of the frame.
        if (edge_pulse) begin
          if (!last_bit) begin
            short_rev_d = 1'b1;
            slot_d      = slot_q + SLOT_W'(1);
          end
          state_d   = tf_new ? ST_CALIB : ST_CAPTURE;
          timer_d   = '0;
          bit_idx_d = '0;
          byte_d    = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      too_fast_q   <= 1'b0;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      slot_q       <= '0;
      byte_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      short_rev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      too_fast_q   <= too_fast_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      slot_q       <= slot_d;
      byte_q       <= byte_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      short_rev_q  <= short_rev_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign short_rev  = short_rev_q;
  assign too_fast   = too_fast_q;
  assign period     = period_q;

endmodule

// File: tb/tb_led_capture.sv
// Bench for led_capture: a table of revolutions (sensor spacing, pixel
// pattern, expected writes, period and pulse counts) is played cycle by
// cycle; a monitor scores every write against an expected-write queue.
module tb_led_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        sensor;
  logic        led;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        short_rev;
  logic        too_fast;
  logic [31:0] period;

  always #5 clk = ~clk;

  led_capture #(.CNT_W(32), .PIX_SHIFT(5), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .led        (led),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .short_rev  (short_rev),
    .too_fast   (too_fast),
    .period     (period)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One revolution: sensor rise at cycle 0 (if has_edge), len cycles long.
  // bp is the bit period the DUT uses for the frame started by this edge
  // (0 = no capture). nbytes/slot describe the writes this frame produces.
  // fd/sr say whether this frame ends in frame_done or short_rev.
  typedef struct {
    bit          has_edge;
    int          len;
    int          bp;
    logic [31:0] pix;
    int          nbytes;
    int          slot;
    int          exp_period;
    int          exp_tf;
    int          fd;
    int          sr;
    int          rst_at;
    bit          rst_before;
  } row_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  row_t rows[$];
  wr_t  exp_q[$];
  int   fd_cnt = 0;
  int   sr_cnt = 0;
  bit   mon_on = 1'b0;

  function automatic row_t mk(bit e, int len, int bp, logic [31:0] pix, int nb,
                              int slot, int per, int tf, int fd, int sr,
                              int rst_at, bit rb);
    row_t r;
    r.has_edge = e;   r.len = len;   r.bp = bp;       r.pix = pix;
    r.nbytes = nb;    r.slot = slot; r.exp_period = per;
    r.exp_tf = tf;    r.fd = fd;     r.sr = sr;
    r.rst_at = rst_at; r.rst_before = rb;
    return r;
  endfunction

  // Pixel i of a frame starting at cycle 'start' occupies bp cycles.
  function automatic logic pix_at(longint c, longint start, int bp, logic [31:0] pix);
    longint idx;
    if (bp == 0 || c < start) return 1'b0;
    idx = (c - start) / bp;
    if (idx >= 32) return 1'b0;
    return pix[31 - idx];
  endfunction

  // Write scoreboard and pulse counters.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (wr_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=no write",
                     wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
        if (frame_done) begin
          fd_cnt++;
          chk("frame_done_with_wr_en", wr_en, 1);
        end
        if (short_rev) sr_cnt++;
      end
    end
  end

  initial begin
    row_t        r;
    wr_t         w;
    longint      abs_c;
    longint      cur_start, prev_start;
    int          cur_bp, prev_bp;
    logic [31:0] cur_pix, prev_pix;
    int          exp_fd, exp_sr;

    reset = 1'b1;
    sensor = 1'b0;
    led = 1'b0;

    //             edge len  bp  pix           nb slot per  tf fd sr rst  rb
    // basic capture at 320-cycle revolutions, slot wrap
    rows.push_back(mk(1, 320, 0,  32'h0,        0, 0,  -1, -1, 0, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hA53CFF00, 4, 0, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hA63CFF00, 4, 1, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hA73CFF00, 4, 2, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hA83CFF00, 4, 3, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hA93CFF00, 4, 0, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'hAA3CFF00, 4, 1, 320,  0, 1, 0, -1, 0));
    // short revolution after 160 cycles: two bytes, then bit period 5
    rows.push_back(mk(1, 160, 10, 32'hC33C5A96, 2, 2, 320,  0, 0, 1, -1, 0));
    rows.push_back(mk(1, 160, 5,  32'h0F1E2D3C, 4, 3, 160,  0, 1, 0, -1, 0));
    // long revolutions: frame completes early, FSM waits for the edge
    rows.push_back(mk(1, 400, 5,  32'h81422418, 4, 0, 160,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 400, 12, 32'hDEADBEEF, 4, 1, 400,  0, 1, 0, -1, 0));
    rows.push_back(mk(0, 500, 0,  32'h0,        0, 0, 400,  0, 0, 0, -1, 0));
    // too fast (60-cycle revolutions), then recovery at 640
    rows.push_back(mk(1, 60,  0,  32'h0,        0, 0,  -1, -1, 0, 0, -1, 1));
    rows.push_back(mk(1, 60,  0,  32'h0,        0, 0,  60,  1, 0, 0, -1, 0));
    rows.push_back(mk(1, 640, 0,  32'h0,        0, 0,  60,  1, 0, 0, -1, 0));
    rows.push_back(mk(1, 640, 20, 32'h12345678, 4, 0, 640,  0, 1, 0, -1, 0));
    // reset during bit 13 (cycles 264..283 of the frame row)
    rows.push_back(mk(1, 400, 20, 32'h96000000, 1, 1, 640,  0, 0, 0, 270, 0));
    // two edges needed before capture resumes; edge lands on bit 31 end
    rows.push_back(mk(1, 320, 0,  32'h0,        0, 0,  -1, -1, 0, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'h5AA55AA5, 4, 0, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(1, 320, 10, 32'h01020304, 4, 1, 320,  0, 1, 0, -1, 0));
    rows.push_back(mk(0, 400, 0,  32'h0,        0, 0, 320,  0, 0, 0, -1, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_short_rev", short_rev, 0);
    chk("reset_too_fast", too_fast, 0);
    chk("reset_period", period, 0);
    @(negedge clk);
    reset = 1'b0;
    mon_on = 1'b1;

    abs_c = 0;
    cur_start = 0;  cur_bp = 0;  cur_pix = '0;
    prev_start = 0; prev_bp = 0; prev_pix = '0;
    exp_fd = 0;
    exp_sr = 0;

    for (int i = 0; i < rows.size(); i++) begin
      r = rows[i];
      if (r.rst_before) begin
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur_bp = 0;
        prev_bp = 0;
      end
      if (r.has_edge) begin
        prev_start = cur_start; prev_bp = cur_bp; prev_pix = cur_pix;
        // 3-cycle edge latency, then the FSM enters capture one cycle later
        cur_start = abs_c + 4;
        cur_bp = r.bp;
        cur_pix = r.pix;
      end
      for (int j = 0; j < r.nbytes; j++) begin
        w.addr = 4'(r.slot * 4 + j);
        w.data = r.pix[31 - 8*j -: 8];
        exp_q.push_back(w);
      end
      for (int n = 0; n < r.len; n++) begin
        @(negedge clk);
        sensor = r.has_edge && (n < 4);
        reset = (n == r.rst_at);
        if (n == r.rst_at) begin
          cur_bp = 0;
          prev_bp = 0;
        end
        led = (abs_c >= cur_start) ? pix_at(abs_c, cur_start, cur_bp, cur_pix)
                                   : pix_at(abs_c, prev_start, prev_bp, prev_pix);
        @(posedge clk);
        #1;
        if (n == r.rst_at)
          chk("outputs_after_reset",
              {wr_en, wr_addr, wr_data, frame_done, short_rev, too_fast, period}, 0);
        if (n == 19) begin
          if (r.exp_period >= 0) chk("period", period, r.exp_period);
          if (r.exp_tf >= 0) chk("too_fast", too_fast, r.exp_tf);
          chk("frame_done_count", fd_cnt, exp_fd);
          chk("short_rev_count", sr_cnt, exp_sr);
        end
        abs_c++;
      end
      exp_fd += r.fd;
      exp_sr += r.sr;
    end

    chk("pending_writes", exp_q.size(), 0);
    chk("final_frame_done_count", fd_cnt, exp_fd);
    chk("final_short_rev_count", sr_cnt, exp_sr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
